// File: rtl/muxn_reg.sv
// muxn_reg: N:1 WIDTH-bit registered mux with valid/ready on every channel
// and on the output. Selection is external (sel) or round-robin over the
// valid channels. Also counts completed output transfers.

// Per-channel slice: ready gating and AND-masked data contribution.
module muxn_reg_lane #(
  parameter int WIDTH = 8
) (
  input  logic             load_ok,
  input  logic             gnt,
  input  logic [WIDTH-1:0] din,
  output logic             rdy,
  output logic [WIDTH-1:0] dout
);
  assign rdy  = load_ok & gnt;
  assign dout = gnt ? din : '0;
endmodule

module muxn_reg #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  parameter  int MODE   = 0,
  parameter  int CNT_W  = 16,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] d,
  input  logic [NUM_CH-1:0]       d_valid,
  output logic [NUM_CH-1:0]       d_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        z,
  output logic [SEL_W-1:0]        z_ch,
  output logic                    z_valid,
  input  logic                    z_ready,
  output logic [CNT_W-1:0]        xfer_cnt
);
  logic                         load_en, load_ok, in_xfer, rr_hit;
  logic [SEL_W-1:0]             gnt_idx, rr_ptr;
  logic [NUM_CH-1:0]            gnt_oh;
  logic [NUM_CH-1:0][WIDTH-1:0] lane_d;
  logic [WIDTH-1:0]             mux_d;

  // The output register can take a word whenever it is empty or draining.
  // Held off in reset so no channel sees ready while the block is cleared.
  assign load_en = !z_valid || z_ready;
  assign load_ok = rst_n && load_en;

  // One-hot grant. Round-robin scans offsets from rr_ptr so the nearest
  // valid channel at or after the pointer wins; out-of-range sel matches
  // no channel and therefore grants nothing.
  always_comb begin
    gnt_oh = '0;
    rr_hit = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++)
        gnt_oh[i] = d_valid[i] && (sel == SEL_W'(i));
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        for (int i = 0; i < NUM_CH; i++)
          if (!rr_hit && d_valid[i] && (((int'(rr_ptr) + k) % NUM_CH) == i)) begin
            gnt_oh[i] = 1'b1;
            rr_hit    = 1'b1;
          end
    end
  end

  // Encode the granted channel index for z_ch and the pointer update.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt_oh[i]) gnt_idx = SEL_W'(i);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    muxn_reg_lane #(.WIDTH(WIDTH)) u_lane (
      .load_ok (load_ok),
      .gnt     (gnt_oh[i]),
      .din     (d[i*WIDTH +: WIDTH]),
      .rdy     (d_ready[i]),
      .dout    (lane_d[i])
    );
  end

  // Grant is one-hot, so OR-combining the masked lanes yields the mux.
  always_comb begin
    mux_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      mux_d = mux_d | lane_d[i];
  end

  assign in_xfer = |(d_valid & d_ready);

  // Output register, transfer counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z        <= '0;
      z_ch     <= '0;
      z_valid  <= 1'b0;
      xfer_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      if (in_xfer) begin
        z       <= mux_d;
        z_ch    <= gnt_idx;
        z_valid <= 1'b1;
      end else if (z_ready) begin
        z_valid <= 1'b0;
      end
      if (z_valid && z_ready)
        xfer_cnt <= xfer_cnt + 1'b1;
      if (MODE == 1 && in_xfer)
        rr_ptr <= (gnt_idx == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_muxn_reg.sv
// tb_muxn_reg: scoreboard bench for muxn_reg. Three instances:
//   A: external select, 4 ch, 4-bit counter (reset, back-pressure, wrap)
//   B: external select, 3 ch (out-of-range select)
//   C: round-robin, 4 ch, 16-bit counter (fairness, full throughput)
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge, where z_valid/z_ready show the handshake of the next edge.
module tb_muxn_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [31:0] a_d;  logic [3:0] a_dv, a_dr; logic [1:0] a_sel, a_zch;
  logic [7:0]  a_z;  logic a_zv, a_zr;       logic [3:0] a_cnt;
  logic [23:0] b_d;  logic [2:0] b_dv, b_dr; logic [1:0] b_sel, b_zch;
  logic [7:0]  b_z;  logic b_zv, b_zr;       logic [15:0] b_cnt;
  logic [31:0] c_d;  logic [3:0] c_dv, c_dr; logic [1:0] c_sel, c_zch;
  logic [7:0]  c_z;  logic c_zv, c_zr;       logic [15:0] c_cnt;

  logic [9:0] qa[$];
  logic [9:0] qc[$];
  logic [9:0] ea, ec;

  muxn_reg #(.WIDTH(8), .NUM_CH(4), .MODE(0), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .d(a_d), .d_valid(a_dv), .d_ready(a_dr),
    .sel(a_sel), .z(a_z), .z_ch(a_zch), .z_valid(a_zv), .z_ready(a_zr),
    .xfer_cnt(a_cnt));

  muxn_reg #(.WIDTH(8), .NUM_CH(3), .MODE(0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .d(b_d), .d_valid(b_dv), .d_ready(b_dr),
    .sel(b_sel), .z(b_z), .z_ch(b_zch), .z_valid(b_zv), .z_ready(b_zr),
    .xfer_cnt(b_cnt));

  muxn_reg #(.WIDTH(8), .NUM_CH(4), .MODE(1), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .d(c_d), .d_valid(c_dv), .d_ready(c_dr),
    .sel(c_sel), .z(c_z), .z_ch(c_zch), .z_valid(c_zv), .z_ready(c_zr),
    .xfer_cnt(c_cnt));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_dv = '0; b_dv = '0; c_dv = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard monitor, instance A: every output transfer pops one word.
  always @(negedge clk) begin
    if (rst_n && a_zv && a_zr) begin
      if (qa.size() == 0) begin
        checks++; errs++;
        $display("FAIL a_sb: unexpected word ch=%0d z=%0h, none expected", a_zch, a_z);
      end else begin
        ea = qa.pop_front();
        chk("a_sb_word", {22'd0, a_zch, a_z}, {22'd0, ea});
      end
    end
  end

  // Scoreboard monitor, instance C.
  always @(negedge clk) begin
    if (rst_n && c_zv && c_zr) begin
      if (qc.size() == 0) begin
        checks++; errs++;
        $display("FAIL c_sb: unexpected word ch=%0d z=%0h, none expected", c_zch, c_z);
      end else begin
        ec = qc.pop_front();
        chk("c_sb_word", {22'd0, c_zch, c_z}, {22'd0, ec});
      end
    end
  end

  initial begin
    int seq_rr [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};
    logic [3:0] exp_oh;
    logic [1:0] ch;
    int zv_bad;

    a_d = '0; a_dv = '0; a_sel = '0; a_zr = 1'b0;
    b_d = '0; b_dv = '0; b_sel = '0; b_zr = 1'b0;
    c_d = '0; c_dv = '0; c_sel = '0; c_zr = 1'b0;

    // Reset state, with every channel valid: no ready while in reset.
    #12;
    a_dv = '1; b_dv = '1; c_dv = '1; a_zr = 1'b1; c_zr = 1'b1;
    #1;
    chk("rst_z",      a_z,   8'h00);
    chk("rst_zch",    a_zch, 2'd0);
    chk("rst_zvalid", a_zv,  1'b0);
    chk("rst_cnt",    a_cnt, 4'd0);
    chk("rst_ready_a", a_dr, 4'b0000);
    chk("rst_ready_b", b_dr, 3'b000);
    chk("rst_ready_c", c_dr, 4'b0000);
    chk("rst_zvalid_c", c_zv, 1'b0);
    a_dv = '0; b_dv = '0; c_dv = '0;
    #10 rst_n = 1'b1;
    tick();

    // Load one word, then reset asynchronously between edges.
    a_d = {24'h0, 8'hA5}; a_dv = 4'b0001; a_sel = 2'd0; a_zr = 1'b1;
    @(negedge clk);
    chk("ld_ready", a_dr, 4'b0001);
    qa.push_back({2'd0, 8'hA5});
    tick();
    a_dv = 4'b0000;
    @(negedge clk);
    chk("ld_z",      a_z,  8'hA5);
    chk("ld_zvalid", a_zv, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_z",      a_z,   8'h00);
    chk("async_rst_zvalid", a_zv,  1'b0);
    chk("async_rst_cnt",    a_cnt, 4'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Fixed select with back-pressure.
    a_d = {8'h11, 8'h3C, 8'h22, 8'h33}; a_sel = 2'd2; a_dv = 4'hF; a_zr = 1'b0;
    @(negedge clk);
    chk("bp_ready", a_dr, 4'b0100);
    qa.push_back({2'd2, 8'h3C});
    tick();
    a_d[23:16] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", a_dr, 4'b0000);
      chk("bp_hold", {a_zch, a_z}, {2'd2, 8'h3C});
      chk("bp_zvalid", a_zv, 1'b1);
      tick();
    end
    a_zr = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", a_dr, 4'b0100);
    qa.push_back({2'd2, 8'h77});
    tick();
    a_dv = 4'b0000;
    @(negedge clk);
    chk("bp_cnt1", a_cnt, 4'd1);
    chk("bp_next_word", {a_zch, a_z}, {2'd2, 8'h77});
    tick();
    tick();

    // Out-of-range select on a 3-channel block.
    b_d = {8'h93, 8'h92, 8'h91}; b_sel = 2'd3; b_dv = 3'b111; b_zr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("oor_ready",  b_dr, 3'b000);
      chk("oor_zvalid", b_zv, 1'b0);
      tick();
    end
    b_sel = 2'd2;
    @(negedge clk);
    chk("sel2_ready", b_dr, 3'b100);
    tick();
    b_dv = 3'b000;
    @(negedge clk);
    chk("sel2_word",   {b_zch, b_z}, {2'd2, 8'h93});
    chk("sel2_zvalid", b_zv, 1'b1);
    tick();

    // Round-robin fairness: all valid, then alternate channels only.
    for (int k = 0; k < 4; k++) c_d[k*8 +: 8] = 8'(32'hC0 + k);
    c_dv = 4'hF; c_zr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) c_dv = 4'b1010;
      ch = 2'(seq_rr[i]);
      exp_oh = 4'b0001 << ch;
      @(negedge clk);
      chk("rr_ready", c_dr, exp_oh);
      qc.push_back({ch, 8'(32'hC0 + seq_rr[i])});
      tick();
    end
    c_dv = 4'h0;
    tick();
    tick();

    // Full throughput: 100 back-to-back words.
    do_reset();
    c_zr = 1'b1;
    zv_bad = 0;
    for (int i = 0; i < 102; i++) begin
      c_dv = (i < 100) ? 4'hF : 4'h0;
      for (int k = 0; k < 4; k++) c_d[k*8 +: 8] = 8'(i*7 + k*3);
      @(negedge clk);
      if (i < 100) qc.push_back({2'(i % 4), 8'(i*7 + (i % 4)*3)});
      if (i >= 1 && i <= 100 && !c_zv) zv_bad++;
      if (i == 100) chk("tp_cnt99", c_cnt, 16'd99);
      if (i == 101) begin
        chk("tp_cnt100", c_cnt, 16'd100);
        chk("tp_idle",   c_zv,  1'b0);
      end
      tick();
    end
    chk("tp_zvalid_gaps", zv_bad, 0);

    // Counter wrap on the 4-bit counter: 17 transfers.
    do_reset();
    chk("wrap_rst_cnt", a_cnt, 4'd0);
    a_sel = 2'd1; a_zr = 1'b1;
    for (int i = 0; i < 19; i++) begin
      a_dv = (i <= 16) ? 4'b0010 : 4'b0000;
      a_d[15:8] = 8'(32'h40 + i);
      @(negedge clk);
      if (i <= 16) qa.push_back({2'd1, 8'(32'h40 + i)});
      if (i == 16) chk("wrap_cnt15", a_cnt, 4'd15);
      if (i == 17) chk("wrap_cnt0",  a_cnt, 4'd0);
      if (i == 18) chk("wrap_cnt1",  a_cnt, 4'd1);
      tick();
    end

    chk("qa_drained", qa.size(), 0);
    chk("qc_drained", qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
